// File: rtl/fetch_pkg.sv
// Instruction field layout and shared types for the fetch/issue front end.
package fetch_pkg;

  localparam int BR_BIT   = 31;
  localparam int IMM_BIT  = 30;
  localparam int CODE_MSB = 29;
  localparam int CODE_LSB = 27;
  localparam int RD_MSB   = 26;
  localparam int RD_LSB   = 23;
  localparam int RS1_MSB  = 22;
  localparam int RS1_LSB  = 19;
  localparam int RS2_MSB  = 18;
  localparam int RS2_LSB  = 15;
  localparam int IMM_MSB  = 14;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] sext_imm(input logic [31:0] instr);
    return {{(31 - IMM_MSB){instr[IMM_MSB]}}, instr[IMM_MSB:0]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched {instruction, address} entries.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // The producer never pushes when full and never pops when empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue front end: credit-limited fetch, response buffering,
// field split for decode and flush on branch redirect.
module instr_fetch_issue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PC_STEP    = 4,
  localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              branchBoolean,
  output logic              immediateBoolean,
  output logic [2:0]        Code,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [31:0]       imm,
  output logic [ADDR_W-1:0] dec_pc,
  output fetch_state_t      fsm_state,
  output logic [CNT_W-1:0]  outstanding
);

  // Handshakes: a transfer happens on a cycle where valid && ready; a valid
  // source holds its payload stable until that cycle.
  localparam int                E_W   = 32 + ADDR_W;
  localparam int                SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  fetch_state_t      state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] rsp_pc, rsp_pc_nx;
  logic [CNT_W-1:0]  out_nx, fifo_count, cnt_nx;
  logic              req_fire, push, pop, req_valid_nx;
  logic [E_W-1:0]    head;
  logic [31:0]       word;

  // Requests are strictly sequential, so the address of the next response is
  // the oldest outstanding address; one register replaces an address queue.
  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    push      = imem_rsp_valid && (fsm_state == FETCH) && !redirect_valid;
    pop       = dec_valid && dec_ready && !redirect_valid;
    out_nx    = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    cnt_nx    = redirect_valid ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    pc_nx     = redirect_valid ? redirect_pc : (req_fire ? pc + STEP : pc);
    rsp_pc_nx = redirect_valid ? redirect_pc : (push ? rsp_pc + STEP : rsp_pc);
    state_nx  = fsm_state;
    if (redirect_valid) begin
      state_nx = (out_nx != '0) ? DRAIN : FETCH;
    end else if ((fsm_state == DRAIN) && (out_nx == '0)) begin
      state_nx = FETCH;
    end
    req_valid_nx = (state_nx == FETCH) &&
                   ((SUM_W'(out_nx) + SUM_W'(cnt_nx)) < SUM_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state      <= FETCH;
      pc             <= RESET_PC;
      rsp_pc         <= RESET_PC;
      outstanding    <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      fsm_state      <= state_nx;
      pc             <= pc_nx;
      rsp_pc         <= rsp_pc_nx;
      outstanding    <= out_nx;
      imem_req_valid <= req_valid_nx;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (E_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   ({imem_rsp_data, rsp_pc}),
    .count (fifo_count),
    .head  (head)
  );

  assign imem_req_addr = pc;
  assign dec_valid     = (fifo_count != '0);

  // Fields read as zero whenever nothing is presented.
  assign word             = dec_valid ? head[E_W-1:ADDR_W] : '0;
  assign dec_pc           = dec_valid ? head[ADDR_W-1:0] : '0;
  assign branchBoolean    = word[BR_BIT];
  assign immediateBoolean = word[IMM_BIT];
  assign Code             = word[CODE_MSB:CODE_LSB];
  assign rd               = word[RD_MSB:RD_LSB];
  assign rs1              = word[RS1_MSB:RS1_LSB];
  assign rs2              = word[RS2_MSB:RS2_LSB];
  assign imm              = sext_imm(word);

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue: decode vector table plus hand-written
// backpressure, redirect, drain and mid-stream reset sequences.
module tb_instr_fetch_issue;
  import fetch_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int NVEC   = 7;
  localparam int W_DEC  = 0;
  localparam int W_REQ  = 1;
  localparam int W_FET  = 2;
  localparam int W_OUT2 = 3;
  localparam int W_RSPD = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req_valid, imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [31:0]       imem_rsp_data = '0;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid, dec_ready;
  logic              branchBoolean, immediateBoolean;
  logic [2:0]        Code;
  logic [3:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic [ADDR_W-1:0] dec_pc;
  fetch_state_t      fsm_state;
  logic [CNT_W-1:0]  outstanding;

  always #5 clk = ~clk;

  instr_fetch_issue dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .branchBoolean    (branchBoolean),
    .immediateBoolean (immediateBoolean),
    .Code             (Code),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .dec_pc           (dec_pc),
    .fsm_state        (fsm_state),
    .outstanding      (outstanding)
  );

  // ---------------- memory model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       due;
  } req_t;

  logic [31:0] mem [256];
  req_t        pend_q[$];
  logic [31:0] cyc = '0;
  int          mem_lat = 1;
  int          acc_count = 0;

  always begin
    req_t h;
    @(posedge clk);
    cyc = cyc + 1;
    if (imem_rsp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
    if (rst) begin
      pend_q.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      acc_count++;
    end
    #1;
    if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
      h = pend_q[0];
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem[h.addr[9:2]];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // ---------------- scoreboard / checks ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int what);
    case (what)
      W_DEC:   return dec_valid;
      W_REQ:   return imem_req_valid;
      W_FET:   return fsm_state == FETCH;
      W_OUT2:  return outstanding == CNT_W'(2);
      default: return imem_rsp_valid && dec_valid;
    endcase
  endfunction

  task automatic wait_for(input int what, input string tag);
    int n = 0;
    while (!cond(what) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!cond(what)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", tag, n);
    end
  endtask

  function automatic logic [63:0] fields_now();
    return {15'b0, branchBoolean, immediateBoolean, Code, rd, rs1, rs2, imm};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000 + 32'(i);
  endtask

  task automatic two_outstanding_then_redirect(input logic [ADDR_W-1:0] tgt);
    load_default();
    mem_lat = 3;
    dec_ready = 1'b1;
    do_reset();
    wait_for(W_OUT2, "reach_two_outstanding");
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] word;
    logic        br;
    logic        ib;
    logic [2:0]  code;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[NVEC];

  // ---------------- test ----------------
  initial begin
    int n;
    vecs[0] = '{32'hC800_0000, 1'b1, 1'b1, 3'd1, 4'd0,  4'd0,  4'd0,  32'h0000_0000};
    vecs[1] = '{32'h0800_0000, 1'b0, 1'b0, 3'd1, 4'd0,  4'd0,  4'd0,  32'h0000_0000};
    vecs[2] = '{32'h3800_4001, 1'b0, 1'b0, 3'd7, 4'd0,  4'd0,  4'd0,  32'hFFFF_C001};
    vecs[3] = '{32'h2800_3FFF, 1'b0, 1'b0, 3'd5, 4'd0,  4'd0,  4'd0,  32'h0000_3FFF};
    vecs[4] = '{32'h1234_5678, 1'b0, 1'b0, 3'd2, 4'd4,  4'd6,  4'd8,  32'hFFFF_D678};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 3'd7, 4'd15, 4'd15, 4'd15, 32'hFFFF_FFFF};
    vecs[6] = '{32'h45A4_1234, 1'b0, 1'b1, 3'd0, 4'd11, 4'd4,  4'd8,  32'h0000_1234};

    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    load_default();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_dec_pc", dec_pc, 0);
    check("rst_fields", fields_now(), 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_state", fsm_state, FETCH);

    // Basic stream and decode table, latency 1, always ready.
    for (int i = 0; i < NVEC; i++) mem[i] = vecs[i].word;
    dec_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 0);
    @(negedge clk);
    check("dec_latency_early", dec_valid, 0);
    @(negedge clk);
    check("dec_latency", dec_valid, 1);
    for (int i = 0; i < NVEC; i++) begin
      wait_for(W_DEC, "vec_wait");
      check($sformatf("vec%0d_fields", i), fields_now(),
            {15'b0, vecs[i].br, vecs[i].ib, vecs[i].code, vecs[i].rd,
             vecs[i].rs1, vecs[i].rs2, vecs[i].imm});
      check($sformatf("vec%0d_pc", i), dec_pc, 64'(4 * i));
      @(negedge clk);
    end

    // Backpressure: credits cap accepted requests, head held stable.
    load_default();
    dec_ready = 1'b0;
    do_reset();
    acc_count = 0;
    repeat (10) begin
      @(negedge clk);
      if (dec_valid) begin
        check("hold_pc", dec_pc, 0);
        check("hold_imm", imm, 32'h0000_1000);
      end
    end
    check("bp_accepted", acc_count, DEPTH);
    check("bp_req_valid", imem_req_valid, 0);
    check("bp_dec_valid", dec_valid, 1);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h0000_1000 + 32'(i));
    dec_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      wait_for(W_DEC, "bp_wait");
      e = exp_q.pop_front();
      check($sformatf("bp_imm%0d", n), imm, e);
      check($sformatf("bp_pc%0d", n), dec_pc, 64'(4 * n));
      n++;
      @(negedge clk);
    end

    // Redirect with two requests in flight, latency 3.
    two_outstanding_then_redirect(16'h0040);
    check("redir_dec_valid", dec_valid, 0);
    check("redir_state", fsm_state, DRAIN);
    check("redir_outstanding", outstanding, 2);
    n = 0;
    while (fsm_state == DRAIN && n < 20) begin
      check("drain_no_req", imem_req_valid, 0);
      check("drain_no_dec", dec_valid, 0);
      @(negedge clk);
      n++;
    end
    wait_for(W_FET, "drain_exit");
    wait_for(W_REQ, "redir_req_wait");
    check("redir_req_addr", imem_req_addr, 16'h0040);
    wait_for(W_DEC, "redir_dec_wait");
    check("redir_dec_pc", dec_pc, 16'h0040);
    check("redir_dec_imm", imm, 32'h0000_1010);

    // Redirect in the same cycle as a response and a pop.
    load_default();
    mem_lat = 1;
    dec_ready = 1'b1;
    do_reset();
    wait_for(W_RSPD, "same_cycle_wait");
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("same_dec_valid", dec_valid, 0);
    check("same_outstanding", outstanding, 0);
    check("same_state", fsm_state, FETCH);
    wait_for(W_DEC, "same_dec_wait");
    check("same_pc0", dec_pc, 16'h0020);
    check("same_imm0", imm, 32'h0000_1008);
    @(negedge clk);
    wait_for(W_DEC, "same_dec_wait1");
    check("same_pc1", dec_pc, 16'h0024);
    check("same_imm1", imm, 32'h0000_1009);

    // Redirect again while draining.
    two_outstanding_then_redirect(16'h0040);
    check("drain2_state", fsm_state, DRAIN);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drain2_still", fsm_state, DRAIN);
    wait_for(W_FET, "drain2_exit");
    wait_for(W_REQ, "drain2_req_wait");
    check("drain2_req_addr", imem_req_addr, 16'h0080);
    wait_for(W_DEC, "drain2_dec_wait");
    check("drain2_dec_pc", dec_pc, 16'h0080);
    check("drain2_dec_imm", imm, 32'h0000_1020);

    // Reset mid-stream with a full buffer.
    load_default();
    mem_lat = 1;
    dec_ready = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    check("full_dec_valid", dec_valid, 1);
    check("full_req_valid", imem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_dec_valid", dec_valid, 0);
    check("mid_rst_req_addr", imem_req_addr, 0);
    check("mid_rst_outstanding", outstanding, 0);
    check("mid_rst_req_valid", imem_req_valid, 0);
    check("mid_rst_dec_pc", dec_pc, 0);
    rst = 1'b0;
    dec_ready = 1'b1;
    wait_for(W_DEC, "post_rst_wait");
    check("post_rst_pc", dec_pc, 0);
    check("post_rst_imm", imm, 32'h0000_1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
